line_clear_engine: RTL

- Owns the ROWS x COLS playfield bit-array.
- Sits directly upstream of the game-control FSM. It produces that FSM's lock, line-full, line-count and game-over inputs.
- On a lock request it merges the landed piece into the board, detects full rows, compacts the board downward and reports the result.
- The display renderer reads the board through a combinational row port.

---
 rtl/line_clear_engine.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/line_clear_engine.sv
// Playfield owner: merges locked pieces, finds full rows, compacts the board downward and reports the result.
// Optional clear-flash hold phase is enabled by defining CLEAR_FLASH_EN.
module line_clear_engine #(
    parameter int          ROWS         = 20,
    parameter int          COLS         = 10,
    parameter logic [23:0] FLASH_CYCLES = 24'd6250000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clear,
    input  logic                i_lock,
    input  logic [4:0]          i_lock_y,
    input  logic [4*COLS-1:0]   i_lock_mask,
    input  logic [4:0]          i_rd_row,
    output logic [COLS-1:0]     o_rd_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_line_full,
    output logic [3:0]          o_line_cnt,
    output logic                o_top_out,
    output logic [ROWS-1:0]     o_full_rows
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MERGE,
        S_CHECK,
`ifdef CLEAR_FLASH_EN
        S_FLASH,
`endif
        S_COMPACT,
        S_FILL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [COLS-1:0]     board_q [ROWS];
    logic [COLS-1:0]     board_d [ROWS];
    logic [4:0]          lock_y_q, lock_y_d;
    logic [4*COLS-1:0]   lock_mask_q, lock_mask_d;
    logic                collide_q, collide_d;
    logic [ROWS-1:0]     full_rows_q, full_rows_d;
    logic [2:0]          n_q, n_d;
    logic [4:0]          rp_q, rp_d;
    logic [4:0]          wp_q, wp_d;
    logic [3:0]          line_cnt_q, line_cnt_d;
    logic                line_full_q, line_full_d;
    logic                top_out_q, top_out_d;
`ifdef CLEAR_FLASH_EN
    logic [23:0]         flash_cnt_q, flash_cnt_d;
`endif

    logic [ROWS-1:0]     full_now;
    logic [4:0]          full_cnt;
    logic [2:0]          n_sat;
    logic [5:0]          tgt;
    logic [COLS-1:0]     mask_row;

    always_comb begin
        full_now = '0;
        full_cnt = '0;
        for (int r = 0; r < ROWS; r++) begin
            full_now[r] = &board_q[r];
            full_cnt    = full_cnt + 5'(full_now[r]);
        end
        n_sat = (full_cnt > 5'd4) ? 3'd4 : full_cnt[2:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            for (int r = 0; r < ROWS; r++) board_q[r] <= '0;
            lock_y_q    <= '0;
            lock_mask_q <= '0;
            collide_q   <= 1'b0;
            full_rows_q <= '0;
            n_q         <= '0;
            rp_q        <= '0;
            wp_q        <= '0;
            line_cnt_q  <= '0;
            line_full_q <= 1'b0;
            top_out_q   <= 1'b0;
`ifdef CLEAR_FLASH_EN
            flash_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            for (int r = 0; r < ROWS; r++) board_q[r] <= board_d[r];
            lock_y_q    <= lock_y_d;
            lock_mask_q <= lock_mask_d;
            collide_q   <= collide_d;
            full_rows_q <= full_rows_d;
            n_q         <= n_d;
            rp_q        <= rp_d;
            wp_q        <= wp_d;
            line_cnt_q  <= line_cnt_d;
            line_full_q <= line_full_d;
            top_out_q   <= top_out_d;
`ifdef CLEAR_FLASH_EN
            flash_cnt_q <= flash_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        for (int r = 0; r < ROWS; r++) board_d[r] = board_q[r];
        lock_y_d    = lock_y_q;
        lock_mask_d = lock_mask_q;
        collide_d   = collide_q;
        full_rows_d = full_rows_q;
        n_d         = n_q;
        rp_d        = rp_q;
        wp_d        = wp_q;
        line_cnt_d  = line_cnt_q;
        line_full_d = line_full_q;
        top_out_d   = top_out_q;
        tgt         = '0;
        mask_row    = '0;
`ifdef CLEAR_FLASH_EN
        flash_cnt_d = flash_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_lock) begin
                    lock_y_d    = i_lock_y;
                    lock_mask_d = i_lock_mask;
                    state_d     = S_MERGE;
                end
            end
            S_MERGE: begin
                collide_d = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    tgt      = {1'b0, lock_y_q} + 6'(k);
                    mask_row = lock_mask_q[k*COLS +: COLS];
                    if (tgt < 6'(ROWS)) begin
                        if (|(board_q[tgt[4:0]] & mask_row)) collide_d = 1'b1;
                        board_d[tgt[4:0]] = board_q[tgt[4:0]] | mask_row;
                    end
                end
                state_d = S_CHECK;
            end
            S_CHECK: begin
                full_rows_d = full_now;
                n_d         = n_sat;
                rp_d        = LAST_ROW;
                wp_d        = LAST_ROW;
`ifdef CLEAR_FLASH_EN
                flash_cnt_d = '0;
                state_d     = (n_sat != 3'd0) ? S_FLASH : S_COMPACT;
`else
                state_d     = S_COMPACT;
`endif
            end
`ifdef CLEAR_FLASH_EN
            S_FLASH: begin
                if (flash_cnt_q == FLASH_CYCLES - 24'd1) state_d = S_COMPACT;
                else flash_cnt_d = flash_cnt_q + 24'd1;
            end
`endif
            // Full rows were latched in CHECK, so skipping uses that mask rather than the moving board.
            S_COMPACT: begin
                if (!full_rows_q[rp_q]) begin
                    board_d[wp_q] = board_q[rp_q];
                    wp_d          = wp_q - 5'd1;
                end
                rp_d = rp_q - 5'd1;
                if (rp_q == 5'd0) state_d = (n_q == 3'd0) ? S_DONE : S_FILL;
            end
            // After compaction wp sits at n-1, so filling ends when row 0 is zeroed.
            S_FILL: begin
                board_d[wp_q] = '0;
                wp_d          = wp_q - 5'd1;
                if (wp_q == 5'd0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE && state_q != S_DONE) begin
            line_cnt_d  = {1'b0, n_q};
            line_full_d = (n_q != 3'd0);
            top_out_d   = collide_q | (|board_d[0]);
        end

        if (i_clear) begin
            state_d     = S_IDLE;
            for (int r = 0; r < ROWS; r++) board_d[r] = '0;
            collide_d   = 1'b0;
            full_rows_d = '0;
            line_cnt_d  = '0;
            line_full_d = 1'b0;
            top_out_d   = 1'b0;
        end
    end

    assign o_rd_data   = (i_rd_row < 5'(ROWS)) ? board_q[i_rd_row] : '0;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
    assign o_line_full = line_full_q;
    assign o_line_cnt  = line_cnt_q;
    assign o_top_out   = top_out_q;
    assign o_full_rows = full_rows_q;

endmodule
